cell_plot_engine: RTL
=====================

// Module: cell_plot_engine
// PURPOSE
//  Rasterises drawing requests into per-pixel writes for the VGA adapter.
//  Sits between the drawing controller and vga_adapter.
//  Two request types:
//  - cell fill: one CELL_WIDTH x CELL_WIDTH square at a cell coordinate.
//  - screen clear: a sweep of every pixel.
//  Requests use a valid/ready handshake; output is one pixel per clock.
// PARAMETERS
//  SCREEN_WIDTH   160     visible pixels per row
//  SCREEN_HEIGHT  120     visible pixel rows
//  CELL_WIDTH     5       cell edge length in pixels
//  CLEAR_COLOUR   3'b111  colour written by a clear sweep (white)
// PORTS
//  iClk        in   1   system clock (CLOCK_50)
//  iReset      in   1   asynchronous, active-high reset
//  iValid      in   1   fill request valid
//  oReady      out  1   engine idle; a fill or clear is accepted this cycle
//  iX_cell     in   8   fill cell column
//  iY_cell     in   8   fill cell row
//  iColour     in   3   fill colour
//  iClearReq   in   1   clear request, level or pulse; sticky until serviced
//  oX_pixel    out  $clog2(SCREEN_WIDTH)+1   pixel x (9 bits at default)
//  oY_pixel    out  $clog2(SCREEN_HEIGHT)+1  pixel y (8 bits at default)
//  oColour     out  3   pixel colour
//  oPlot       out  1   pixel write strobe to vga_adapter
//  oDone       out  1   one-cycle pulse when a request completes
//  oBusy       out  1   state != IDLE
// BEHAVIOUR
//  Reset:
//  - All outputs 0, including oReady. Pending-clear flag 0. State IDLE.
//  - oReady rises at the first iClk edge after iReset falls.
//  - Reset mid-operation aborts the operation immediately; no oDone is issued.
//  States:
//  - IDLE:  oReady=1.
//    - Pending clear (or iClearReq high) -> CLEAR. Clear has priority.
//    - else iValid -> FILL; latch cell, colour and base address.
//    - A fill is never accepted in the same cycle a clear is taken.
//  - FILL:  px,py in 0..CELL_WIDTH-1, px fastest.
//    - oX = iX_cell*CELL_WIDTH + px;  oY = iY_cell*CELL_WIDTH + py.
//    - Multiplies are done once, at accept time, into registered bases.
//  - CLEAR: x in 0..SCREEN_WIDTH-1, y in 0..SCREEN_HEIGHT-1, x fastest.
//    - oColour = CLEAR_COLOUR.
//  - DONE:  oDone=1, oPlot=0 for one cycle, then IDLE (oReady=1 next cycle).
//  Timing:
//  - Outputs are registered. Accept at edge k -> first oPlot in cycle k+1.
//  - oPlot stays high for every cycle of the sweep, with no gaps:
//    - fill: CELL_WIDTH^2 cycles (25);
//    - clear: SCREEN_WIDTH*SCREEN_HEIGHT cycles (19200).
//  - oDone follows in the cycle after the last plot.
//  Range check:
//  - If iX_cell >= SCREEN_WIDTH/CELL_WIDTH or iY_cell >= SCREEN_HEIGHT/CELL_WIDTH,
//    the fill is still accepted, but the engine goes straight to DONE.
//  - No oPlot is issued for an out-of-range fill.
//  Clear pending flag:
//  - iClearReq while busy sets the flag; it is serviced on the next IDLE cycle.
//  - Multiple clear requests merge into one sweep.
//  - The flag clears when CLEAR is entered.
//  Arithmetic and data:
//  - Counters are sized to their parameter range and wrap only via the state exit.
//  - Latched request data is immune to input changes during the sweep.
//  - iValid held while busy is consumed exactly once.
// TESTING
//  1. Fill (2,3), colour 3'b100.
//     -> 25 plots: x 10..14, y 15..19, raster order, colour 100.
//     -> oDone in cycle 26 after accept.
//  2. Fill (32,0).
//     -> zero plots; oDone one cycle after accept; oReady the next cycle.
//  3. iClearReq pulsed mid-fill.
//     -> fill finishes intact, then 19200 plots colour 111.
//     -> last plot (159,119); oDone pulses twice in total.
//  4. iValid and iClearReq high together in IDLE.
//     -> clear accepted first; the fill is accepted after the clear's oDone.
//  5. iReset at clear pixel 5000.
//     -> oPlot=0 and oBusy=0 at once; no oDone.
//     -> after release, oReady=1 and a new fill runs normally.
//  6. iValid held high across two back-to-back fills with changing inputs.
//     -> each accepted once; pixels use the values latched at accept.

Source files
------------

// File: rtl/cell_plot_engine.sv
// Rasterising engine between the drawing controller and vga_adapter.
// Converts cell-fill and screen-clear requests into one pixel write per clock.
module cell_plot_engine #(
  parameter int         SCREEN_WIDTH  = 160,
  parameter int         SCREEN_HEIGHT = 120,
  parameter int         CELL_WIDTH    = 5,
  parameter logic [2:0] CLEAR_COLOUR  = 3'b111
) (
  input  logic                            iClk,
  input  logic                            iReset,
  input  logic                            iValid,
  output logic                            oReady,
  input  logic [7:0]                      iX_cell,
  input  logic [7:0]                      iY_cell,
  input  logic [2:0]                      iColour,
  input  logic                            iClearReq,
  output logic [$clog2(SCREEN_WIDTH):0]   oX_pixel,
  output logic [$clog2(SCREEN_HEIGHT):0]  oY_pixel,
  output logic [2:0]                      oColour,
  output logic                            oPlot,
  output logic                            oDone,
  output logic                            oBusy
);

  localparam int XW = $clog2(SCREEN_WIDTH) + 1;
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1;
  localparam int PW = (CELL_WIDTH > 1) ? $clog2(CELL_WIDTH) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(CELL_WIDTH - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(SCREEN_HEIGHT - 1);
  localparam logic [7:0]    CELLS_X = 8'(SCREEN_WIDTH / CELL_WIDTH);
  localparam logic [7:0]    CELLS_Y = 8'(SCREEN_HEIGHT / CELL_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CLEAR,
    DONE
  } state_t;

  state_t          state;
  logic [XW-1:0]   base_x;
  logic [YW-1:0]   base_y;
  logic [XW-1:0]   mul_x;
  logic [YW-1:0]   mul_y;
  logic [PW-1:0]   px;
  logic [PW-1:0]   py;
  logic            clear_pend;
  logic            in_range;

  // Cell-to-pixel base address and range test for the request on the inputs
  always_comb begin
    mul_x    = XW'(iX_cell) * XW'(CELL_WIDTH);
    mul_y    = YW'(iY_cell) * YW'(CELL_WIDTH);
    in_range = (iX_cell < CELLS_X) && (iY_cell < CELLS_Y);
  end

  // Request arbitration, sweep counters and registered pixel outputs
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state      <= IDLE;
      base_x     <= '0;
      base_y     <= '0;
      px         <= '0;
      py         <= '0;
      clear_pend <= 1'b0;
      oReady     <= 1'b0;
      oX_pixel   <= '0;
      oY_pixel   <= '0;
      oColour    <= '0;
      oPlot      <= 1'b0;
      oDone      <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      clear_pend <= clear_pend | iClearReq;
      case (state)
        IDLE: begin
          oDone <= 1'b0;
          oPlot <= 1'b0;
          // oReady is low only on the first cycle after reset; nothing is
          // accepted until it has been presented high for a full cycle.
          if (!oReady) begin
            oReady <= 1'b1;
          end else if (clear_pend || iClearReq) begin
            state      <= CLEAR;
            clear_pend <= 1'b0;
            oReady     <= 1'b0;
            oBusy      <= 1'b1;
            oX_pixel   <= '0;
            oY_pixel   <= '0;
            oColour    <= CLEAR_COLOUR;
            oPlot      <= 1'b1;
          end else if (iValid) begin
            oReady  <= 1'b0;
            oBusy   <= 1'b1;
            base_x  <= mul_x;
            base_y  <= mul_y;
            px      <= '0;
            py      <= '0;
            oColour <= iColour;
            if (in_range) begin
              state    <= FILL;
              oX_pixel <= mul_x;
              oY_pixel <= mul_y;
              oPlot    <= 1'b1;
            end else begin
              state <= DONE;
              oDone <= 1'b1;
            end
          end
        end

        FILL: begin
          if (px == P_LAST) begin
            px <= '0;
            if (py == P_LAST) begin
              state <= DONE;
              oPlot <= 1'b0;
              oDone <= 1'b1;
            end else begin
              py       <= py + 1'b1;
              oX_pixel <= base_x;
              oY_pixel <= base_y + YW'(py + 1'b1);
            end
          end else begin
            px       <= px + 1'b1;
            oX_pixel <= base_x + XW'(px + 1'b1);
          end
        end

        // The output coordinate registers double as the clear sweep counters
        CLEAR: begin
          if (oX_pixel == X_LAST) begin
            oX_pixel <= '0;
            if (oY_pixel == Y_LAST) begin
              state <= DONE;
              oPlot <= 1'b0;
              oDone <= 1'b1;
            end else begin
              oY_pixel <= oY_pixel + 1'b1;
            end
          end else begin
            oX_pixel <= oX_pixel + 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          oDone  <= 1'b0;
          oPlot  <= 1'b0;
          oBusy  <= 1'b0;
          oReady <= 1'b1;
        end

        default: begin
          state  <= IDLE;
          oPlot  <= 1'b0;
          oDone  <= 1'b0;
          oBusy  <= 1'b0;
          oReady <= 1'b0;
        end
      endcase
    end
  end

endmodule
